matrix_directory_engine: RTL and testbench

MATRIX_DIRECTORY_ENGINE -- requirements
Module: matrix_directory_engine

---
 rtl/matrix_directory_engine_if.sv | 52 +++++
 rtl/matrix_directory_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_matrix_directory_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_directory_engine_if.sv
// rtl/matrix_directory_engine_if.sv - request/result/query bundle for matrix_directory_engine
// master drives requests and query index; slave is the directory engine.
interface matrix_directory_engine_if #(
  parameter int SLOT_W = 5,
  parameter int DIM_W  = 5,
  parameter int ADDR_W = 12
);
  logic [SLOT_W-1:0] cfg_per_dim;
  logic              alloc_req;
  logic [DIM_W-1:0]  alloc_m;
  logic [DIM_W-1:0]  alloc_n;
  logic              alloc_ready;
  logic              alloc_done;
  logic              alloc_ok;
  logic              alloc_reuse;
  logic [SLOT_W-1:0] alloc_slot;
  logic [ADDR_W-1:0] alloc_addr;
  logic              commit_req;
  logic [SLOT_W-1:0] commit_slot;
  logic [DIM_W-1:0]  commit_m;
  logic [DIM_W-1:0]  commit_n;
  logic [ADDR_W-1:0] commit_addr;
  logic              free_req;
  logic [SLOT_W-1:0] free_slot;
  logic              cmd_err;
  logic [SLOT_W-1:0] query_slot;
  logic              query_valid;
  logic [DIM_W-1:0]  query_m;
  logic [DIM_W-1:0]  query_n;
  logic [ADDR_W-1:0] query_addr;
  logic [ADDR_W-1:0] query_count;
  logic [SLOT_W-1:0] total_count;
  logic [15:0]       fail_count;

  modport master (
    output cfg_per_dim, alloc_req, alloc_m, alloc_n,
    output commit_req, commit_slot, commit_m, commit_n, commit_addr,
    output free_req, free_slot, query_slot,
    input  alloc_ready, alloc_done, alloc_ok, alloc_reuse, alloc_slot, alloc_addr,
    input  cmd_err, query_valid, query_m, query_n, query_addr, query_count,
    input  total_count, fail_count
  );

  modport slave (
    input  cfg_per_dim, alloc_req, alloc_m, alloc_n,
    input  commit_req, commit_slot, commit_m, commit_n, commit_addr,
    input  free_req, free_slot, query_slot,
    output alloc_ready, alloc_done, alloc_ok, alloc_reuse, alloc_slot, alloc_addr,
    output cmd_err, query_valid, query_m, query_n, query_addr, query_count,
    output total_count, fail_count
  );
endinterface

// File: rtl/matrix_directory_engine.sv
// rtl/matrix_directory_engine.sv - matrix storage directory with scanning allocator
// Optional total/fail statistics counters are built when MATRIX_DIR_STATS_EN is defined.
module matrix_directory_engine #(
  parameter int NUM_SLOTS    = 20,
  parameter int SLOT_W       = 5,
  parameter int DIM_W        = 5,
  parameter int ADDR_W       = 12,
  parameter int MAX_ELEMENTS = 4096,
  parameter int AGE_W        = 16
) (
  input logic clk,
  input logic rst_n,
  matrix_directory_engine_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam int EW = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;
  state_t state_q, state_d;

  logic [NUM_SLOTS-1:0] valid_q;
  logic [DIM_W-1:0]     dm_q    [NUM_SLOTS];
  logic [DIM_W-1:0]     dn_q    [NUM_SLOTS];
  logic [ADDR_W-1:0]    daddr_q [NUM_SLOTS];
  logic [AGE_W-1:0]     dage_q  [NUM_SLOTS];
  logic [AGE_W-1:0]     global_age_q;

  logic [SLOT_W-1:0] idx_q, free_slot_q, old_slot_q, dim_cnt_q;
  logic              free_found_q;
  logic [EW-1:0]     max_end_q;
  logic [AGE_W-1:0]  old_diff_q;
  logic [DIM_W-1:0]  req_m_q, req_n_q;

  logic              res_ok_q, res_reuse_q, cmd_err_q;
  logic [SLOT_W-1:0] res_slot_q;
  logic [ADDR_W-1:0] res_addr_q;

  logic do_commit, do_free, do_alloc;
  logic commit_in, free_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    do_free   = 1'b0;
    do_alloc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.commit_req)     do_commit = 1'b1;
        else if (bus.free_req)  do_free   = 1'b1;
        else if (bus.alloc_req) begin
          do_alloc = 1'b1;
          state_d  = SCAN;
        end
      end
      SCAN:    if (idx_q == SLOT_W'(NUM_SLOTS - 1)) state_d = DECIDE;
      DECIDE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign commit_in = bus.commit_slot < SLOT_W'(NUM_SLOTS);
  assign free_in   = bus.free_slot < SLOT_W'(NUM_SLOTS);

  // Per-slot view of the entry currently under the scan pointer.
  logic [PW-1:0]    slot_prod;
  logic [EW-1:0]    slot_end;
  logic [AGE_W-1:0] age_diff;
  logic             slot_match;
  assign slot_prod  = PW'(dm_q[idx_q]) * PW'(dn_q[idx_q]);
  assign slot_end   = EW'(daddr_q[idx_q]) + EW'(slot_prod);
  assign age_diff   = global_age_q - dage_q[idx_q];
  assign slot_match = valid_q[idx_q] && (dm_q[idx_q] == req_m_q) && (dn_q[idx_q] == req_n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      free_found_q <= 1'b0;
      free_slot_q  <= '0;
      max_end_q    <= '0;
      dim_cnt_q    <= '0;
      old_slot_q   <= '0;
      old_diff_q   <= '0;
      req_m_q      <= '0;
      req_n_q      <= '0;
    end else if (do_alloc) begin
      idx_q        <= '0;
      free_found_q <= 1'b0;
      free_slot_q  <= '0;
      max_end_q    <= '0;
      dim_cnt_q    <= '0;
      old_slot_q   <= '0;
      old_diff_q   <= '0;
      req_m_q      <= bus.alloc_m;
      req_n_q      <= bus.alloc_n;
    end else if (state_q == SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (!valid_q[idx_q]) begin
        if (!free_found_q) begin
          free_found_q <= 1'b1;
          free_slot_q  <= idx_q;
        end
      end else begin
        if (slot_end > max_end_q) max_end_q <= slot_end;
        if (slot_match) begin
          dim_cnt_q <= dim_cnt_q + 1'b1;
          // Strict compare keeps the lowest index on equal ages.
          if (dim_cnt_q == '0 || age_diff > old_diff_q) begin
            old_slot_q <= idx_q;
            old_diff_q <= age_diff;
          end
        end
      end
    end
  end

  logic [SLOT_W-1:0] limit;
  logic [PW-1:0]     req_prod;
  logic              dec_ok, dec_reuse;
  logic [SLOT_W-1:0] dec_slot;
  logic [ADDR_W-1:0] dec_addr;

  always_comb begin
    limit     = bus.cfg_per_dim;
    if (bus.cfg_per_dim == '0) limit = SLOT_W'(1);
    else if (bus.cfg_per_dim > SLOT_W'(NUM_SLOTS)) limit = SLOT_W'(NUM_SLOTS);
    req_prod  = PW'(req_m_q) * PW'(req_n_q);
    dec_ok    = 1'b0;
    dec_reuse = 1'b0;
    dec_slot  = '1;
    dec_addr  = '0;
    if (req_m_q == '0 || req_n_q == '0) begin
      dec_ok = 1'b0;
    end else if (dim_cnt_q >= limit) begin
      dec_ok    = 1'b1;
      dec_reuse = 1'b1;
      dec_slot  = old_slot_q;
      dec_addr  = daddr_q[old_slot_q];
    end else if (free_found_q && (max_end_q + EW'(req_prod) <= EW'(MAX_ELEMENTS))) begin
      dec_ok   = 1'b1;
      dec_slot = free_slot_q;
      dec_addr = max_end_q[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_ok_q    <= 1'b0;
      res_reuse_q <= 1'b0;
      res_slot_q  <= '1;
      res_addr_q  <= '0;
    end else if (state_q == DECIDE) begin
      res_ok_q    <= dec_ok;
      res_reuse_q <= dec_reuse;
      res_slot_q  <= dec_slot;
      res_addr_q  <= dec_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      global_age_q <= '0;
      cmd_err_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        dm_q[i]    <= '0;
        dn_q[i]    <= '0;
        daddr_q[i] <= '0;
        dage_q[i]  <= '0;
      end
    end else begin
      cmd_err_q <= 1'b0;
      if (do_commit) begin
        if (commit_in) begin
          valid_q[bus.commit_slot] <= 1'b1;
          dm_q[bus.commit_slot]    <= bus.commit_m;
          dn_q[bus.commit_slot]    <= bus.commit_n;
          daddr_q[bus.commit_slot] <= bus.commit_addr;
          dage_q[bus.commit_slot]  <= global_age_q;
          global_age_q             <= global_age_q + 1'b1;
        end else begin
          cmd_err_q <= 1'b1;
        end
      end else if (do_free) begin
        if (free_in) valid_q[bus.free_slot] <= 1'b0;
        else         cmd_err_q <= 1'b1;
      end
    end
  end

  assign bus.alloc_ready = (state_q == IDLE);
  assign bus.alloc_done  = (state_q == DONE);
  assign bus.alloc_ok    = (state_q == DONE) && res_ok_q;
  assign bus.alloc_reuse = (state_q == DONE) && res_reuse_q;
  assign bus.alloc_slot  = res_slot_q;
  assign bus.alloc_addr  = res_addr_q;
  assign bus.cmd_err     = cmd_err_q;

  logic q_in;
  assign q_in = bus.query_slot < SLOT_W'(NUM_SLOTS);

  always_comb begin
    bus.query_valid = 1'b0;
    bus.query_m     = '0;
    bus.query_n     = '0;
    bus.query_addr  = '0;
    bus.query_count = '0;
    if (q_in) begin
      bus.query_valid = valid_q[bus.query_slot];
      bus.query_m     = dm_q[bus.query_slot];
      bus.query_n     = dn_q[bus.query_slot];
      bus.query_addr  = daddr_q[bus.query_slot];
      bus.query_count = ADDR_W'(PW'(dm_q[bus.query_slot]) * PW'(dn_q[bus.query_slot]));
    end
  end

`ifdef MATRIX_DIR_STATS_EN
  logic [SLOT_W-1:0] total_q;
  logic [15:0]       fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      fail_q  <= '0;
    end else begin
      if (do_commit && commit_in && !valid_q[bus.commit_slot]) total_q <= total_q + 1'b1;
      else if (do_free && free_in && valid_q[bus.free_slot])   total_q <= total_q - 1'b1;
      if (state_q == DONE && !res_ok_q && fail_q != 16'hFFFF)  fail_q  <= fail_q + 1'b1;
    end
  end

  assign bus.total_count = total_q;
  assign bus.fail_count  = fail_q;
`else
  assign bus.total_count = '0;
  assign bus.fail_count  = '0;
`endif
endmodule

// File: tb/tb_matrix_directory_engine.sv
// tb/tb_matrix_directory_engine.sv - scoreboard bench for matrix_directory_engine
// Directed allocations push expected results; a negedge monitor pops and compares them.
module tb_matrix_directory_engine;
  localparam int NUM_SLOTS = 20;
  localparam int SLOT_W    = 5;
  localparam int DIM_W     = 5;
  localparam int ADDR_W    = 12;
  localparam int LAT       = NUM_SLOTS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_directory_engine_if #(.SLOT_W(SLOT_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) bus ();

  matrix_directory_engine #(
    .NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .DIM_W(DIM_W),
    .ADDR_W(ADDR_W), .MAX_ELEMENTS(4096), .AGE_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic              ok;
    logic              reuse;
    logic [SLOT_W-1:0] slot;
    logic [ADDR_W-1:0] addr;
    int                done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.alloc_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_alloc_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("alloc_ok",      32'(bus.alloc_ok),    32'(mon_e.ok));
        check("alloc_reuse",   32'(bus.alloc_reuse), 32'(mon_e.reuse));
        check("alloc_slot",    32'(bus.alloc_slot),  32'(mon_e.slot));
        check("alloc_addr",    32'(bus.alloc_addr),  32'(mon_e.addr));
        check("alloc_latency", 32'(cyc),             32'(mon_e.done_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.alloc_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) check("done_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic commit(input logic [SLOT_W-1:0] s, input logic [DIM_W-1:0] m,
                        input logic [DIM_W-1:0] n, input logic [ADDR_W-1:0] a);
    wait_ready();
    bus.commit_req  = 1'b1;
    bus.commit_slot = s;
    bus.commit_m    = m;
    bus.commit_n    = n;
    bus.commit_addr = a;
    tick();
    bus.commit_req  = 1'b0;
  endtask

  task automatic free_cmd(input logic [SLOT_W-1:0] s);
    wait_ready();
    bus.free_req  = 1'b1;
    bus.free_slot = s;
    tick();
    bus.free_req  = 1'b0;
  endtask

  task automatic alloc(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n, input logic ok,
                       input logic reuse, input logic [SLOT_W-1:0] slot, input logic [ADDR_W-1:0] addr);
    wait_ready();
    bus.alloc_req = 1'b1;
    bus.alloc_m   = m;
    bus.alloc_n   = n;
    exp_q.push_back('{ok, reuse, slot, addr, cyc + LAT});
    tick();
    bus.alloc_req = 1'b0;
    drain();
  endtask

  task automatic query(input string name, input logic [SLOT_W-1:0] s, input logic v,
                       input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n, input logic [ADDR_W-1:0] a);
    bus.query_slot = s;
    #1;
    check({name, "_valid"}, 32'(bus.query_valid), 32'(v));
    if (v) begin
      check({name, "_m"},     32'(bus.query_m),     32'(m));
      check({name, "_n"},     32'(bus.query_n),     32'(n));
      check({name, "_addr"},  32'(bus.query_addr),  32'(a));
      check({name, "_count"}, 32'(bus.query_count), 32'(m) * 32'(n));
    end
  endtask

  task automatic check_stats(input int exp_total, input int exp_fail);
`ifdef MATRIX_DIR_STATS_EN
    check("total_count", 32'(bus.total_count), 32'(exp_total));
    check("fail_count",  32'(bus.fail_count),  32'(exp_fail));
`else
    check("total_count", 32'(bus.total_count), 32'(exp_total) & 32'd0);
    check("fail_count",  32'(bus.fail_count),  32'(exp_fail) & 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_per_dim = 5'd4;
    bus.alloc_req   = 1'b0;
    bus.alloc_m     = '0;
    bus.alloc_n     = '0;
    bus.commit_req  = 1'b0;
    bus.commit_slot = '0;
    bus.commit_m    = '0;
    bus.commit_n    = '0;
    bus.commit_addr = '0;
    bus.free_req    = 1'b0;
    bus.free_slot   = '0;
    bus.query_slot  = '0;
    rst_n = 1'b0;
    tick();
    tick();

    // Values held while reset is asserted
    check("rst_alloc_done",  32'(bus.alloc_done),  32'd0);
    check("rst_alloc_ok",    32'(bus.alloc_ok),    32'd0);
    check("rst_alloc_reuse", 32'(bus.alloc_reuse), 32'd0);
    check("rst_cmd_err",     32'(bus.cmd_err),     32'd0);
    check("rst_alloc_slot",  32'(bus.alloc_slot),  32'h1f);
    check("rst_alloc_addr",  32'(bus.alloc_addr),  32'd0);
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    query("rst_q0", 5'd0, 1'b0, '0, '0, '0);
    check_stats(0, 0);
    rst_n = 1'b1;
    tick();

    // First allocation into an empty directory
    alloc(5'd3, 5'd4, 1'b1, 1'b0, 5'd0, 12'd0);
    query("noalloc_mod", 5'd0, 1'b0, '0, '0, '0);

    commit(5'd0, 5'd3, 5'd4, 12'd0);
    query("q0", 5'd0, 1'b1, 5'd3, 5'd4, 12'd0);
    alloc(5'd2, 5'd2, 1'b1, 1'b0, 5'd1, 12'd12);
    alloc(5'd0, 5'd3, 1'b0, 1'b0, 5'h1f, 12'd0);
    tick();
    check_stats(1, 1);

    // Per-dimension limit and oldest-slot reuse
    do_reset();
    query("rst2_q0", 5'd0, 1'b0, '0, '0, '0);
    commit(5'd0, 5'd3, 5'd3, 12'd0);
    bus.cfg_per_dim = 5'd0;
    alloc(5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 12'd0);
    bus.cfg_per_dim = 5'd2;
    alloc(5'd3, 5'd3, 1'b1, 1'b0, 5'd1, 12'd9);
    commit(5'd1, 5'd3, 5'd3, 12'd9);
    alloc(5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 12'd0);
    commit(5'd0, 5'd3, 5'd3, 12'd0);
    alloc(5'd3, 5'd3, 1'b1, 1'b1, 5'd1, 12'd9);
    alloc(5'd2, 5'd2, 1'b1, 1'b0, 5'd2, 12'd18);
    check_stats(2, 0);

    // Capacity boundary near the top of storage
    do_reset();
    bus.cfg_per_dim = 5'd4;
    commit(5'd0, 5'd2, 5'd5, 12'd4080);
    alloc(5'd3, 5'd3, 1'b0, 1'b0, 5'h1f, 12'd0);
    alloc(5'd2, 5'd3, 1'b1, 1'b0, 5'd1, 12'd4090);
    tick();
    check_stats(1, 1);

    // Out-of-range commands
    commit(5'd25, 5'd1, 5'd1, 12'd7);
    check("cmd_err_commit", 32'(bus.cmd_err), 32'd1);
    tick();
    check("cmd_err_clear", 32'(bus.cmd_err), 32'd0);
    query("q25", 5'd25, 1'b0, '0, '0, '0);
    query("q0_kept", 5'd0, 1'b1, 5'd2, 5'd5, 12'd4080);
    free_cmd(5'd25);
    check("cmd_err_free", 32'(bus.cmd_err), 32'd1);
    free_cmd(5'd3);
    check("free_invalid_no_err", 32'(bus.cmd_err), 32'd0);

    // Commit and alloc raised together: commit wins, alloc follows
    wait_ready();
    bus.commit_req  = 1'b1;
    bus.commit_slot = 5'd1;
    bus.commit_m    = 5'd1;
    bus.commit_n    = 5'd1;
    bus.commit_addr = 12'd0;
    bus.alloc_req   = 1'b1;
    bus.alloc_m     = 5'd1;
    bus.alloc_n     = 5'd1;
    tick();
    bus.commit_req = 1'b0;
    check("alloc_held_ready", 32'(bus.alloc_ready), 32'd1);
    exp_q.push_back('{1'b1, 1'b0, 5'd2, 12'd4090, cyc + LAT});
    tick();
    bus.alloc_req = 1'b0;
    drain();
    query("q1_commit", 5'd1, 1'b1, 5'd1, 5'd1, 12'd0);

    free_cmd(5'd0);
    query("q0_freed", 5'd0, 1'b0, '0, '0, '0);
    alloc(5'd3, 5'd3, 1'b1, 1'b0, 5'd0, 12'd1);
    check_stats(1, 1);

    // Reset during a scan aborts it silently
    wait_ready();
    bus.alloc_req = 1'b1;
    bus.alloc_m   = 5'd2;
    bus.alloc_n   = 5'd2;
    tick();
    bus.alloc_req = 1'b0;
    repeat (5) tick();
    check("scan_busy", 32'(bus.alloc_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_ready_async", 32'(bus.alloc_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("abort_ready", 32'(bus.alloc_ready), 32'd1);
    for (int i = 0; i < NUM_SLOTS; i++) query("abort_q", 5'(i), 1'b0, '0, '0, '0);
    check_stats(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
